// File: rtl/usb_decoder.sv
// USB receive decoder: line sync, NRZI decode, bit unstuffing, SE0 EOP detect.
// Optional SYNC pattern check enabled by defining USB_DECODER_SYNC_CHECK_EN.
module usb_decoder #(
  parameter int STUFF_LEN   = 6,
  parameter int EOP_SAMPLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_plus_in,
  input  logic d_minus_in,
  input  logic rx_shift,
  output logic rx_bit,
  output logic rx_bit_valid,
  output logic rx_active,
  output logic rx_eop,
  output logic rx_stuff_err,
  output logic rx_line_err,
  output logic rx_sync_err
);

  typedef enum logic [2:0] {
    IDLE,
    RECEIVE,
    EOP_WAIT,
    EOP_DONE,
    ERROR
  } state_t;

  state_t     state;
  logic       dp_m, dp_s;
  logic       dm_m, dm_s;
  logic       prev_level;
  logic [2:0] ones_cnt;
  logic [1:0] se0_cnt;

`ifdef USB_DECODER_SYNC_CHECK_EN
  logic [3:0] sync_cnt;
  logic       sync_bad;
`endif

  logic       se0, se1, kstate, jstate;
  logic       raw;
  logic       stuff_slot;
  logic [2:0] ones_inc;
  logic [1:0] se0_inc;
  logic       se0_hit;

  assign se0        = ~dp_s & ~dm_s;
  assign se1        = dp_s & dm_s;
  assign kstate     = ~dp_s & dm_s;
  assign jstate     = dp_s & ~dm_s;
  assign raw        = (dp_s == prev_level);
  assign stuff_slot = (ones_cnt == 3'(STUFF_LEN));
  assign ones_inc   = (ones_cnt == 3'd7) ? 3'd7 : ones_cnt + 3'd1;
  assign se0_inc    = se0_cnt + 2'd1;
  assign se0_hit    = (se0_inc == 2'(EOP_SAMPLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_m         <= 1'b1;
      dp_s         <= 1'b1;
      dm_m         <= 1'b0;
      dm_s         <= 1'b0;
      prev_level   <= 1'b1;
      ones_cnt     <= 3'd0;
      se0_cnt      <= 2'd0;
      state        <= IDLE;
      rx_bit       <= 1'b0;
      rx_bit_valid <= 1'b0;
      rx_active    <= 1'b0;
      rx_eop       <= 1'b0;
      rx_stuff_err <= 1'b0;
      rx_line_err  <= 1'b0;
      rx_sync_err  <= 1'b0;
`ifdef USB_DECODER_SYNC_CHECK_EN
      sync_cnt     <= 4'd0;
      sync_bad     <= 1'b0;
`endif
    end else begin
      dp_m         <= d_plus_in;
      dp_s         <= dp_m;
      dm_m         <= d_minus_in;
      dm_s         <= dm_m;
      rx_bit       <= 1'b0;
      rx_bit_valid <= 1'b0;
      rx_eop       <= 1'b0;
      rx_stuff_err <= 1'b0;
      rx_line_err  <= 1'b0;
      rx_sync_err  <= 1'b0;
      if (rx_shift) begin
        unique case (state)
          IDLE: begin
            if (se1) begin
              rx_line_err <= 1'b1;
            end else if (kstate) begin
              // first K after idle J always decodes as a 0
              prev_level <= 1'b0;
              ones_cnt   <= 3'd0;
              se0_cnt    <= 2'd0;
              rx_active  <= 1'b1;
              state      <= RECEIVE;
`ifdef USB_DECODER_SYNC_CHECK_EN
              sync_cnt   <= 4'd1;
              sync_bad   <= 1'b0;
`else
              rx_bit_valid <= 1'b1;
`endif
            end
          end
          RECEIVE: begin
            if (se0) begin
              if (EOP_SAMPLES == 1) begin
                rx_eop    <= 1'b1;
                rx_active <= 1'b0;
                state     <= EOP_DONE;
              end else begin
                se0_cnt <= 2'd1;
                state   <= EOP_WAIT;
              end
            end else if (se1) begin
              rx_line_err <= 1'b1;
              rx_active   <= 1'b0;
              se0_cnt     <= 2'd0;
              state       <= ERROR;
            end else begin
              prev_level <= dp_s;
              if (stuff_slot) begin
                if (raw) begin
                  rx_stuff_err <= 1'b1;
                  rx_active    <= 1'b0;
                  se0_cnt      <= 2'd0;
                  state        <= ERROR;
                end else begin
                  ones_cnt <= 3'd0;
                end
              end else begin
                ones_cnt <= raw ? ones_inc : 3'd0;
`ifdef USB_DECODER_SYNC_CHECK_EN
                if (sync_cnt[3]) begin
                  rx_bit       <= raw;
                  rx_bit_valid <= 1'b1;
                end else if (sync_cnt == 4'd7) begin
                  sync_cnt <= 4'd8;
                  if (sync_bad || !raw) begin
                    rx_sync_err <= 1'b1;
                    rx_active   <= 1'b0;
                    se0_cnt     <= 2'd0;
                    state       <= ERROR;
                  end
                end else begin
                  sync_bad <= sync_bad | raw;
                  sync_cnt <= sync_cnt + 4'd1;
                end
`else
                rx_bit       <= raw;
                rx_bit_valid <= 1'b1;
`endif
              end
            end
          end
          EOP_WAIT: begin
            if (se0) begin
              if (se0_hit) begin
                rx_eop    <= 1'b1;
                rx_active <= 1'b0;
                se0_cnt   <= 2'd0;
                state     <= EOP_DONE;
              end else begin
                se0_cnt <= se0_inc;
              end
            end else if (se1) begin
              rx_line_err <= 1'b1;
              rx_active   <= 1'b0;
              se0_cnt     <= 2'd0;
              state       <= ERROR;
            end else begin
              // short SE0 glitch: drop the sample, keep the pre-SE0 level
              se0_cnt <= 2'd0;
              state   <= RECEIVE;
            end
          end
          EOP_DONE: begin
            if (jstate) begin
              prev_level <= 1'b1;
              ones_cnt   <= 3'd0;
              se0_cnt    <= 2'd0;
              state      <= IDLE;
            end
          end
          ERROR: begin
            rx_active <= 1'b0;
            if (se0) begin
              if (se0_hit) begin
                se0_cnt <= 2'd0;
                state   <= EOP_DONE;
              end else begin
                se0_cnt <= se0_inc;
              end
            end else begin
              se0_cnt <= 2'd0;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_decoder.sv
// Directed bench for usb_decoder: SYNC+data, stuffing, EOP glitch, SE1, reset.
// Line pairs are built by a tiny NRZI encoder; expected bits are hand-written.
module tb_usb_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d_plus_in = 1'b1;
  logic d_minus_in = 1'b0;
  logic rx_shift = 1'b0;
  logic rx_bit, rx_bit_valid, rx_active, rx_eop;
  logic rx_stuff_err, rx_line_err, rx_sync_err;

  int n_vec = 0;
  int n_bad = 0;
  logic lvl = 1'b1;
  logic [15:0] cap = '0;
  int nbits = 0;

  usb_decoder dut (
    .clk(clk),
    .rst(rst),
    .d_plus_in(d_plus_in),
    .d_minus_in(d_minus_in),
    .rx_shift(rx_shift),
    .rx_bit(rx_bit),
    .rx_bit_valid(rx_bit_valid),
    .rx_active(rx_active),
    .rx_eop(rx_eop),
    .rx_stuff_err(rx_stuff_err),
    .rx_line_err(rx_line_err),
    .rx_sync_err(rx_sync_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] st();
    return 32'({rx_active, rx_eop, rx_stuff_err, rx_line_err, rx_sync_err});
  endfunction

  function automatic logic [31:0] all_out();
    return 32'({rx_bit, rx_bit_valid, rx_active, rx_eop,
                rx_stuff_err, rx_line_err, rx_sync_err});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic samp(input logic dp, input logic dm);
    d_plus_in = dp;
    d_minus_in = dm;
    repeat (2) @(negedge clk);
    rx_shift = 1'b1;
    @(negedge clk);
    rx_shift = 1'b0;
    if (rx_bit_valid === 1'b1) begin
      cap = {rx_bit, cap[15:1]};
      nbits++;
    end
  endtask

  task automatic sbit(input logic b);
    if (!b) lvl = ~lvl;
    samp(lvl, ~lvl);
  endtask

  task automatic sbits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) sbit(v[i]);
  endtask

  task automatic clr();
    cap = '0;
    nbits = 0;
  endtask

  task automatic eop_seq(input string tag);
    samp(1'b0, 1'b0);
    samp(1'b0, 1'b0);
    chk(tag, st(), 32'h08);
    samp(1'b1, 1'b0);
    lvl = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_out(), 32'h0);
    rst = 1'b0;

    samp(1'b0, 1'b0);
    chk("idle_se0_ignored", all_out(), 32'h0);
    samp(1'b1, 1'b0);

    // SYNC (0x80) + 0xA5, LSB first
    clr();
    sbits(16'hA580, 16);
    chk("a5_count", 32'(nbits), 32'd16);
    chk("a5_bits", 32'(cap), 32'hA580);
    chk("a5_active", st(), 32'h10);
    samp(1'b0, 1'b0);
    chk("a5_se0_1", st(), 32'h10);
    samp(1'b0, 1'b0);
    chk("a5_eop", st(), 32'h08);
    @(negedge clk);
    chk("a5_eop_one_cycle", st(), 32'h0);
    samp(1'b1, 1'b0);
    chk("a5_idle", all_out(), 32'h0);
    lvl = 1'b1;

    // seven ones without a stuffed zero
    clr();
    sbits(16'h00FE, 8);
    chk("stf_count", 32'(nbits), 32'd7);
    chk("stf_bits", 32'(cap[15:9]), 32'h7E);
    chk("stf_err", st(), 32'h04);
    sbits(16'h0002, 2);
    chk("stf_no_more_bits", 32'(nbits), 32'd7);
    chk("stf_quiet", st(), 32'h0);
    samp(1'b0, 1'b0);
    samp(1'b0, 1'b0);
    chk("stf_no_eop", st(), 32'h0);
    samp(1'b1, 1'b0);
    lvl = 1'b1;

    // six ones, stuffed zero, one
    clr();
    sbits(16'h007E, 8);
    chk("unstuff_drop", 32'(rx_bit_valid), 32'd0);
    chk("unstuff_cnt7", 32'(nbits), 32'd7);
    sbit(1'b1);
    chk("unstuff_cnt8", 32'(nbits), 32'd8);
    chk("unstuff_bits", 32'(cap[15:8]), 32'hFE);
    chk("unstuff_ok", st(), 32'h10);
    eop_seq("unstuff_eop");

    // single SE0 glitch then K glitch sample, then J
    clr();
    sbits(16'h0004, 3);
    samp(1'b0, 1'b0);
    chk("glitch_se0", st(), 32'h10);
    samp(1'b0, 1'b1);
    chk("glitch_drop", 32'({rx_bit_valid, st()[4:0]}), 32'h10);
    samp(1'b1, 1'b0);
    chk("glitch_next_bit", 32'({rx_bit_valid, rx_bit}), 32'h3);
    chk("glitch_count", 32'(nbits), 32'd4);
    eop_seq("glitch_eop");

    // SE1 mid-packet
    clr();
    sbit(1'b0);
    samp(1'b1, 1'b1);
    chk("se1_line_err", st(), 32'h02);
    samp(1'b0, 1'b0);
    samp(1'b0, 1'b0);
    chk("se1_no_eop", st(), 32'h0);
    samp(1'b1, 1'b0);
    lvl = 1'b1;
    clr();
    sbit(1'b0);
    chk("se1_recover_bit", 32'({rx_bit_valid, rx_bit}), 32'h2);
    chk("se1_recover_act", st(), 32'h10);
    sbit(1'b1);
    chk("se1_recover_bit2", 32'({rx_bit_valid, rx_bit}), 32'h3);
    eop_seq("se1_recover_eop");

    // reset in the middle of a packet
    clr();
    sbits(16'h001E, 5);
    chk("rst_pre_active", st(), 32'h10);
    d_plus_in = 1'b1;
    d_minus_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outputs", all_out(), 32'h0);
    rst = 1'b0;
    lvl = 1'b1;
    clr();
    sbits(16'h000E, 4);
    chk("rst_after_count", 32'(nbits), 32'd4);
    chk("rst_after_bits", 32'(cap[15:12]), 32'hE);
    chk("rst_after_act", st(), 32'h10);
    eop_seq("rst_after_eop");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
